// File: rtl/lpc_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : lpc_uart_tx
//  Description : Asynchronous serial transmitter for the sniffer byte stream.
//                Accepts one byte per uart_ready/uart_clock_enable handshake
//                and shifts it out LSB-first as 8N1 or 8N2 at clock/DIVISOR
//                baud.
//                Define LPC_UART_TX_PARITY_EN to add an even-parity bit,
//                which makes the frame 8E1 or 8E2.
//                tx and uart_ready are driven straight from flops.
//  Revision    : 1.0 - initial release
// ============================================================================
module lpc_uart_tx #(
    parameter int DIVISOR   = 104,
    parameter int STOP_BITS = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] uart_data,
    input  logic       uart_clock_enable,
    output logic       uart_ready,
    output logic       tx
);

    localparam logic [15:0] c_div_last  = 16'(DIVISOR - 1);
    localparam logic [2:0]  c_stop_last = 3'(STOP_BITS - 1);

`ifdef LPC_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } state_t;
`endif

    state_t      state_q;
    logic [15:0] div_q;
    // bit_q indexes data bits in DATA and counts stop bits in STOP.
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        tx_q;
    logic        ready_q;
`ifdef LPC_UART_TX_PARITY_EN
    logic        parity_q;
`endif

    logic        w_accept;
    logic        w_bit_end;
    logic        tx_d;

    // ready_q high implies the FSM is idle, so this is the only way to start a frame.
    assign w_accept  = ready_q & uart_clock_enable;
    assign w_bit_end = (div_q == c_div_last);

    assign tx         = tx_q;
    assign uart_ready = ready_q;

    // Line level for the current state; registered below, so tx lags the FSM by one cycle.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[bit_q];
`ifdef LPC_UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    // Frame sequencer with bit-period divider and registered line/ready outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            div_q    <= 16'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
`ifdef LPC_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            tx_q <= tx_d;
            // Ready returns one cycle after the FSM reaches IDLE, and drops on accept.
            ready_q <= (state_q == ST_IDLE) && !w_accept;

            case (state_q)
                ST_IDLE: begin
                    div_q <= 16'd0;
                    bit_q <= 3'd0;
                    if (w_accept) begin
                        shift_q  <= uart_data;
`ifdef LPC_UART_TX_PARITY_EN
                        parity_q <= ^uart_data;
`endif
                        state_q  <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_bit_end) begin
                        div_q   <= 16'd0;
                        bit_q   <= 3'd0;
                        state_q <= ST_DATA;
                    end else begin
                        div_q <= div_q + 16'd1;
                    end
                end

                ST_DATA: begin
                    if (w_bit_end) begin
                        div_q <= 16'd0;
                        if (bit_q == 3'd7) begin
                            bit_q   <= 3'd0;
`ifdef LPC_UART_TX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        div_q <= div_q + 16'd1;
                    end
                end

`ifdef LPC_UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        div_q   <= 16'd0;
                        bit_q   <= 3'd0;
                        state_q <= ST_STOP;
                    end else begin
                        div_q <= div_q + 16'd1;
                    end
                end
`endif

                ST_STOP: begin
                    if (w_bit_end) begin
                        div_q <= 16'd0;
                        if (bit_q == c_stop_last) begin
                            bit_q   <= 3'd0;
                            state_q <= ST_IDLE;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        div_q <= div_q + 16'd1;
                    end
                end

                default: begin
                    div_q   <= 16'd0;
                    bit_q   <= 3'd0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lpc_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lpc_uart_tx
//  Description : Directed self-checking bench for lpc_uart_tx with
//                DIVISOR=4. dut1 uses one stop bit and dut2 uses two.
//                When LPC_UART_TX_PARITY_EN is defined, the expected frames
//                include the even-parity bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lpc_uart_tx;

    localparam int c_div = 4;
`ifdef LPC_UART_TX_PARITY_EN
    localparam int c_par = 1;
`else
    localparam int c_par = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] uart_data = 8'h00;
    logic       en1 = 1'b0;
    logic       en2 = 1'b0;
    logic       ready1, tx1, ready2, tx2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    lpc_uart_tx #(.DIVISOR(c_div), .STOP_BITS(1)) dut1 (
        .clock             (clock),
        .reset             (reset),
        .uart_data         (uart_data),
        .uart_clock_enable (en1),
        .uart_ready        (ready1),
        .tx                (tx1)
    );

    lpc_uart_tx #(.DIVISOR(c_div), .STOP_BITS(2)) dut2 (
        .clock             (clock),
        .reset             (reset),
        .uart_data         (uart_data),
        .uart_clock_enable (en2),
        .uart_ready        (ready2),
        .tx                (tx2)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected line level c cycles after the accept edge.
    function automatic logic exp_tx(input logic [7:0] b, input int c);
        int idx;
        idx = (c - 1) / c_div;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (c_par == 1 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    // Caller has already presented data with enable high while ready is high,
    // so the accept edge is the next rising edge. Checks every cycle up to the
    // ready rise; ends at the negedge after the ready-rise edge.
    task automatic run_frame(input string name, input logic [7:0] b, input int which,
                             input int s, input bit drop_en, input logic [7:0] next_data);
        int   len;
        logic t, r;
        len = 1 + (9 + c_par + s) * c_div;
        @(posedge clock);
        @(negedge clock);
        t = (which == 2) ? tx2 : tx1;
        r = (which == 2) ? ready2 : ready1;
        chk($sformatf("%s accept ready", name), r, 1'b0);
        chk($sformatf("%s accept tx", name), t, 1'b1);
        if (drop_en) begin
            if (which == 2) en2 = 1'b0;
            else            en1 = 1'b0;
        end
        uart_data = next_data;
        for (int c = 1; c <= len; c++) begin
            @(negedge clock);
            t = (which == 2) ? tx2 : tx1;
            r = (which == 2) ? ready2 : ready1;
            chk($sformatf("%s tx c=%0d", name, c), t, exp_tx(b, c));
            chk($sformatf("%s ready c=%0d", name, c), r, (c >= len) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset tx1", tx1, 1'b1);
        chk("reset ready1", ready1, 1'b1);
        chk("reset tx2", tx2, 1'b1);
        chk("reset ready2", ready2, 1'b1);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("idle tx1", tx1, 1'b1);
        chk("idle ready1", ready1, 1'b1);

        // Basic 8N1 frame
        uart_data = 8'h55;
        en1 = 1'b1;
        run_frame("basic55", 8'h55, 1, 1, 1'b1, 8'h00);

        // Serializer-style back-to-back bytes
        @(negedge clock);
        uart_data = 8'hFF;
        en1 = 1'b1;
        run_frame("ser0", 8'hFF, 1, 1, 1'b0, 8'hFF);
        run_frame("ser1", 8'hFF, 1, 1, 1'b0, 8'h01);
        run_frame("ser2", 8'h01, 1, 1, 1'b1, 8'h00);

        // Enable held high, data changed mid-frame
        @(negedge clock);
        uart_data = 8'hA3;
        en1 = 1'b1;
        run_frame("holdA3", 8'hA3, 1, 1, 1'b0, 8'h00);
        run_frame("hold00", 8'h00, 1, 1, 1'b1, 8'h00);

        // Reset during data bit 3
        @(negedge clock);
        uart_data = 8'h5A;
        en1 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        en1 = 1'b0;
        repeat (18) @(negedge clock);
        chk("midframe bit3 tx", tx1, 1'b1);
        chk("midframe ready", ready1, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        chk("midreset tx", tx1, 1'b1);
        chk("midreset ready", ready1, 1'b1);
        reset = 1'b0;
        @(negedge clock);
        uart_data = 8'h3C;
        en1 = 1'b1;
        run_frame("after_reset3C", 8'h3C, 1, 1, 1'b1, 8'h00);

        // Two stop bits
        @(negedge clock);
        uart_data = 8'h00;
        en2 = 1'b1;
        run_frame("stop2_00", 8'h00, 2, 2, 1'b1, 8'h00);

        // Reset together with enable: nothing is accepted
        @(negedge clock);
        reset = 1'b1;
        uart_data = 8'hFF;
        en1 = 1'b1;
        @(negedge clock);
        chk("rst_en ready", ready1, 1'b1);
        chk("rst_en tx", tx1, 1'b1);
        reset = 1'b0;
        en1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk($sformatf("rst_en idle tx %0d", i), tx1, 1'b1);
            chk($sformatf("rst_en idle ready %0d", i), ready1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
